// File: rtl/streebog_core_adder_if.sv
// streebog_core_adder_seq_if: request/result bundle for the chunk-serial adder.
interface streebog_core_adder_seq_if #(parameter int WIDTH = 512);
  logic             ena;
  logic             rdy;
  logic             mode;
  logic             c_in;
  logic             c_out;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;
  modport master (output ena, mode, c_in, x, y, input rdy, sum, c_out);
  modport slave  (input ena, mode, c_in, x, y, output rdy, sum, c_out);
endinterface

// File: rtl/streebog_core_adder_seq.sv
// streebog_core_adder_seq: chunk-serial WIDTH-bit add/subtract, one CHUNK slice per cycle.
module streebog_core_adder_seq #(
  parameter int WIDTH = 512,
  parameter int CHUNK = 32
) (
  input logic                     clk,
  input logic                     reset_n,
  streebog_core_adder_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (N < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("WIDTH must be a nonzero multiple of CHUNK");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_xr, r_yr, r_acc, r_sum, w_acc;
  logic             r_mode, r_carry, r_cout, w_last;
  logic [IW-1:0]    r_idx;
  logic [CHUNK:0]   w_t;
  always_comb begin
    w_t    = {1'b0, r_xr[r_idx*CHUNK +: CHUNK]} + {1'b0, r_yr[r_idx*CHUNK +: CHUNK]} + (CHUNK+1)'(r_carry);
    w_acc  = r_acc;
    w_acc[r_idx*CHUNK +: CHUNK] = w_t[CHUNK-1:0];
    w_last = r_idx == IW'(N-1);
    w_next = r_state == IDLE ? (bus.ena ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  // Subtraction runs as x + ~y + (1 ^ borrow_in); the final carry is inverted into a borrow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_xr    <= '0;
      r_yr    <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (bus.ena) begin
          r_xr    <= bus.x;
          r_yr    <= bus.mode ? ~bus.y : bus.y;
          r_mode  <= bus.mode;
          r_carry <= bus.c_in ^ bus.mode;
          r_idx   <= '0;
        end
      end else begin
        r_acc   <= w_acc;
        r_carry <= w_t[CHUNK];
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_sum  <= w_acc;
          r_cout <= w_t[CHUNK] ^ r_mode;
        end
      end
    end
  end
  assign bus.rdy   = r_state == IDLE;
  assign bus.sum   = r_sum;
  assign bus.c_out = r_cout;
endmodule

// File: tb/tb_streebog_core_adder_seq.sv
// tb_streebog_core_adder_seq: directed table, handshake/reset sequences and random ops vs. an arithmetic model.
module tb_streebog_core_adder_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  streebog_core_adder_seq_if #(.WIDTH(512)) ia();
  streebog_core_adder_seq_if #(.WIDTH(64))  ib();
  streebog_core_adder_seq_if #(.WIDTH(256)) ic();
  streebog_core_adder_seq #(.WIDTH(512), .CHUNK(32)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  streebog_core_adder_seq #(.WIDTH(64),  .CHUNK(64)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));
  streebog_core_adder_seq #(.WIDTH(256), .CHUNK(16)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ic));
  typedef struct {
    logic         m;
    logic         ci;
    logic [511:0] x;
    logic [511:0] y;
    logic [511:0] s;
    logic         co;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int width_of(input int d);
    return d == 0 ? 512 : d == 1 ? 64 : 256;
  endfunction
  function automatic int n_of(input int d);
    return d == 1 ? 1 : 16;
  endfunction
  function automatic logic [511:0] mask_of(input int d);
    logic [511:0] ones;
    ones = '1;
    return ones >> (512 - width_of(d));
  endfunction
  function automatic logic get_rdy(input int d);
    return d == 0 ? ia.rdy : d == 1 ? ib.rdy : ic.rdy;
  endfunction
  function automatic logic get_co(input int d);
    return d == 0 ? ia.c_out : d == 1 ? ib.c_out : ic.c_out;
  endfunction
  function automatic logic [511:0] get_sum(input int d);
    return d == 0 ? ia.sum : d == 1 ? 512'(ib.sum) : 512'(ic.sum);
  endfunction
  task automatic drive(input int d, input logic e, input logic m, input logic ci,
                       input logic [511:0] xv, input logic [511:0] yv);
    case (d)
      0: begin ia.ena = e; ia.mode = m; ia.c_in = ci; ia.x = xv; ia.y = yv; end
      1: begin ib.ena = e; ib.mode = m; ib.c_in = ci; ib.x = xv[63:0]; ib.y = yv[63:0]; end
      default: begin ic.ena = e; ic.mode = m; ic.c_in = ci; ic.x = xv[255:0]; ic.y = yv[255:0]; end
    endcase
  endtask
  // Called just after the accept edge; counts edges until rdy returns (bounded).
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!get_rdy(d) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic op(input int d, input logic m, input logic ci, input logic [511:0] xv,
                    input logic [511:0] yv, output logic [511:0] s, output logic co, output int lat);
    @(negedge clk);
    drive(d, 1'b1, m, ci, xv, yv);
    @(posedge clk);
    #1;
    drive(d, 1'b0, m, ci, xv, yv);
    wait_done(d, lat);
    s  = get_sum(d);
    co = get_co(d);
  endtask
  // Reference: exact signed arithmetic in WIDTH+1 bits; bit WIDTH is the carry or borrow.
  task automatic ref_op(input int d, input logic m, input logic ci, input logic [511:0] xv,
                        input logic [511:0] yv, output logic [511:0] s, output logic co);
    logic [512:0] f;
    f  = m ? ({1'b0, xv} - {1'b0, yv} - 513'(ci)) : ({1'b0, xv} + {1'b0, yv} + 513'(ci));
    s  = f[511:0] & mask_of(d);
    co = f[width_of(d)];
  endtask
  initial begin
    logic [511:0] ones, s, es, xv, yv;
    logic         co, eco, m, ci;
    int           lat, lat2;
    ones = '1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset-rdy", 512'(get_rdy(d)), 512'(1));
      chk("reset-sum", get_sum(d), '0);
      chk("reset-cout", 512'(get_co(d)), '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tbl[0] = '{1'b0, 1'b0, ones, 512'd1, 512'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 512'd0, 512'd1, ones, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 512'd5, 512'd3, 512'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 512'd0, 512'd0, 512'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, ones >> 32, 512'd1, 512'd1 << 480, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 512'd10, 512'd3, 512'd6, 1'b0};
    tbl[6] = '{1'b0, 1'b1, ones, ones, ones, 1'b1};
    for (int i = 0; i < 7; i++) begin
      op(0, tbl[i].m, tbl[i].ci, tbl[i].x, tbl[i].y, s, co, lat);
      chk("table-sum", s, tbl[i].s);
      chk("table-cout", 512'(co), 512'(tbl[i].co));
      chk("table-latency", 512'(lat), 512'd16);
    end
    // Second ena three edges into the run must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 512'd100, 512'd23);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 512'd100, 512'd23);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 512'd7, 512'd7);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 512'd7, 512'd7);
    wait_done(0, lat2);
    chk("ignored-latency", 512'(lat2 + 3), 512'd16);
    chk("ignored-sum", ia.sum, 512'd123);
    chk("ignored-cout", 512'(ia.c_out), '0);
    wait_done(0, lat2);
    chk("ignored-not-queued", 512'(ia.rdy), 512'd1);
    // Back-to-back: ena held high across completion.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 512'd1, 512'd2);
    @(posedge clk);
    #1;
    wait_done(0, lat);
    chk("b2b-lat1", 512'(lat), 512'd16);
    chk("b2b-sum1", ia.sum, 512'd3);
    drive(0, 1'b1, 1'b0, 1'b0, 512'd40, 512'd2);
    @(posedge clk);
    #1;
    chk("b2b-rdy-pulse", 512'(ia.rdy), '0);
    drive(0, 1'b0, 1'b0, 1'b0, 512'd40, 512'd2);
    wait_done(0, lat);
    chk("b2b-lat2", 512'(lat), 512'd16);
    chk("b2b-sum2", ia.sum, 512'd42);
    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, ones, ones);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, ones, ones);
    repeat (6) @(posedge clk);
    #1;
    chk("midrun-busy", 512'(ia.rdy), '0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort-rdy", 512'(ia.rdy), 512'd1);
    chk("abort-sum", ia.sum, '0);
    chk("abort-cout", 512'(ia.c_out), '0);
    @(negedge clk);
    reset_n = 1'b1;
    op(0, 1'b1, 1'b0, 512'd1000, 512'd1, s, co, lat);
    chk("post-reset-sum", s, 512'd999);
    chk("post-reset-cout", 512'(co), '0);
    chk("post-reset-latency", 512'(lat), 512'd16);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < (d == 0 ? 100 : 1000); i++) begin
        for (int k = 0; k < 16; k++) begin
          xv[k*32 +: 32] = $urandom;
          yv[k*32 +: 32] = $urandom;
        end
        xv = xv & mask_of(d);
        yv = yv & mask_of(d);
        m  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: yv = (mask_of(d) - xv) & mask_of(d);
          1: yv = xv;
          2: xv = mask_of(d);
          default: ;
        endcase
        op(d, m, ci, xv, yv, s, co, lat);
        ref_op(d, m, ci, xv, yv, es, eco);
        chk("rand-sum", s, es);
        chk("rand-cout", 512'(co), 512'(eco));
        chk("rand-latency", 512'(lat), 512'(n_of(d)));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
